rca_pipelined_addsub: RTL and testbench
=======================================

// Module: rca_pipelined_addsub
// PURPOSE
//  N-bit ripple-carry add/subtract unit, split into STAGES registered chunks of N/STAGES bits.
//  Each chunk ripples its carry through a chain of full adders.
//  Carry ripples through one chunk per cycle, so Fmax is set by N/STAGES bits instead of N.
//  Valid/ready handshake on both sides gives full throughput with backpressure.
//  Drop-in arithmetic core for datapaths that need wide add/sub at high clock rates.
// PARAMETERS
//  N       16  operand/sum width in bits; N % STAGES == 0 required (elaboration $error otherwise)
//  STAGES  4   number of pipeline stages (1..N); latency in cycles; chunk width W = N/STAGES
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  x/y/cin/sub valid this cycle
//  in_ready   out  1  block accepts operands this cycle (transfer = in_valid & in_ready)
//  x          in   N  operand A (unsigned or two's complement)
//  y          in   N  operand B
//  cin        in   1  carry-in (add) / borrow-in (sub)
//  sub        in   1  0: s = x + y + cin ; 1: s = x - y - cin
//  out_valid  out  1  s/cout/ovf valid
//  out_ready  in   1  downstream accepts result (transfer = out_valid & out_ready)
//  s          out  N  result, mod 2^N
//  cout       out  1  add: carry-out; sub: NOT borrow (1 = no borrow, i.e. x >= y+cin unsigned)
//  ovf        out  1  signed two's-complement overflow of the N-bit result
// BEHAVIOUR
//  - Arithmetic: at acceptance, op_b = sub ? ~y : y ; c0 = sub ? ~cin : cin ; result = x + op_b + c0.
//  - Stage k (0..STAGES-1) adds bits [k*W +: W] of x/op_b with the carry from stage k-1 (c0 for k=0).
//    Stage k registers: the sum chunk; carry-out; the untouched upper x/op_b bits; the lower sum bits
//    already produced; a valid bit.
//  - Stage 0 operates combinationally on the accepted inputs; its result is registered.
//    Latency is exactly STAGES cycles: accept at edge t -> out_valid at edge t+STAGES if no stall.
//  - ovf = (x[N-1] == op_b[N-1]) & (s[N-1] != x[N-1]); MSBs of x/op_b are carried to the last stage.
//    This is equivalent to carry into MSB XOR carry out of MSB.
//  - Flow control, global stall: stall = out_valid & ~out_ready.
//    in_ready = ~stall. While stall=1 no pipeline register changes (data and valid hold).
//    Bubbles are not collapsed.
//  - Throughput: one result per cycle while out_ready=1; in_valid=0 inserts a bubble (valid=0 propagates).
//  - in_valid with in_ready=0: no transfer; the source must hold operands (AXI-style).
//  - out_valid/s/cout/ovf hold stable while out_valid & ~out_ready.
//  - Reset: all stage valid bits clear -> out_valid=0, in_ready=1 in the cycle after rst.
//    Data registers also clear, so s=0, cout=0, ovf=0.
//    rst asserted mid-operation discards all in-flight results; no partial output is ever emitted.
//    rst has priority over a transfer in the same cycle.
//  - STAGES=1: single registered N-bit RCA, latency 1.
//    STAGES=N: 1-bit chunks, latency N.
//  - Wrap-around: s is mod 2^N; cout/ovf are the only indication of overflow.
//    No saturation and no sticky flags.
//  - No combinational path from x/y/cin/sub to any output.
//    Combinational path out_ready -> in_ready is intentional.
// TESTING  (N=8, STAGES=4 unless stated; all values hex)
//  1 rst=1 for 2 cycles, then release -> out_valid=0, in_ready=1, s=00, cout=0, ovf=0.
//  2 add x=FF y=01 cin=0, out_ready=1 -> exactly 4 cycles later: out_valid=1, s=00, cout=1, ovf=0.
//    This exercises carry ripple across every stage.
//  3 sub x=80 y=01 cin=0 -> s=7F, cout=1, ovf=1.
//    sub x=05 y=07 cin=1 -> s=FD, cout=0, ovf=0.
//  4 back-to-back stream of 20 random ops with in_valid=1, out_ready=1 -> 20 results in order,
//    one per cycle, each matching a reference model.
//  5 hold out_ready=0 for 5 cycles while streaming -> in_ready=0 while out_valid=1.
//    Outputs stay stable; after release all results arrive in order with none lost or duplicated.
//  6 rst pulse while 3 ops are in flight -> none emerge.
//    Next op accepted after reset appears 4 cycles later, correct.
//    Repeat 2 and 4 with STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/rca_pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : rca_pipelined_addsub
//  Description : N-bit ripple-carry add/subtract unit cut into STAGES chunks
//                of N/STAGES bits. One chunk ripples per cycle, so the
//                critical path is set by the chunk width. Valid/ready on both
//                sides, global stall, full throughput.
//  Revision    : 1.0  initial release
// ============================================================================
module rca_pipelined_addsub #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    // Chunk width handled by each stage, and index of the output stage.
    localparam int c_chunk_w = N / STAGES;
    localparam int c_last    = STAGES - 1;

    // Reject geometries that cannot be split into equal chunks.
    generate
        if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_bad_params
            $error("rca_pipelined_addsub: N=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= N",
                   N, STAGES);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand conditioning: subtraction is x + ~y + ~cin, so a borrow-in
    // of 1 becomes a carry-in of 0 and the final carry reads as NOT borrow.
    // ------------------------------------------------------------------
    logic [N-1:0] w_op_b;
    logic         w_c0;

    assign w_op_b = sub ? ~y : y;
    assign w_c0   = sub ? ~cin : cin;

    // ------------------------------------------------------------------
    // Pipeline state. Every stage carries the full x/op_b vectors (upper
    // bits still to be added, MSBs needed for overflow at the end), the
    // partial sum with chunks 0..k filled in, the chunk carry and a valid.
    // ------------------------------------------------------------------
    logic [N-1:0]      r_x     [STAGES];
    logic [N-1:0]      r_b     [STAGES];
    logic [N-1:0]      r_s     [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_valid;

    // Next-state values produced by each stage's chunk adder.
    logic [N-1:0]      w_x_nxt [STAGES];
    logic [N-1:0]      w_b_nxt [STAGES];
    logic [N-1:0]      w_s_nxt [STAGES];
    logic [STAGES-1:0] w_c_nxt;

    // Global stall: a result is waiting and nobody takes it.
    logic w_stall;

    assign w_stall  = r_valid[c_last] & ~out_ready;
    assign in_ready = ~w_stall;

    // ------------------------------------------------------------------
    // Per-stage chunk adders
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [N-1:0]         w_xin;
            logic [N-1:0]         w_bin;
            logic [N-1:0]         w_sin;
            logic                 w_cin;
            logic [c_chunk_w-1:0] w_sum;
            logic [c_chunk_w:0]   w_carry;
            logic [N-1:0]         w_snext;

            if (k == 0) begin : g_head
                // First chunk works directly on the accepted operands.
                assign w_xin = x;
                assign w_bin = w_op_b;
                assign w_sin = '0;
                assign w_cin = w_c0;
            end else begin : g_body
                // Later chunks continue from the previous stage register.
                assign w_xin = r_x[k-1];
                assign w_bin = r_b[k-1];
                assign w_sin = r_s[k-1];
                assign w_cin = r_c[k-1];
            end

            // Ripple the carry through a chain of full adders over this chunk.
            always_comb begin
                w_carry    = '0;
                w_sum      = '0;
                w_carry[0] = w_cin;
                for (int i = 0; i < c_chunk_w; i++) begin
                    w_sum[i]     = w_xin[k*c_chunk_w+i] ^ w_bin[k*c_chunk_w+i] ^ w_carry[i];
                    w_carry[i+1] = (w_xin[k*c_chunk_w+i] & w_bin[k*c_chunk_w+i])
                                 | (w_carry[i] & (w_xin[k*c_chunk_w+i] ^ w_bin[k*c_chunk_w+i]));
                end
            end

            // Insert this chunk's sum into the partial result from below.
            always_comb begin
                w_snext                         = w_sin;
                w_snext[k*c_chunk_w+:c_chunk_w] = w_sum;
            end

            assign w_x_nxt[k] = w_xin;
            assign w_b_nxt[k] = w_bin;
            assign w_s_nxt[k] = w_snext;
            assign w_c_nxt[k] = w_carry[c_chunk_w];
        end
    endgenerate

    // Valid bits shift one stage per non-stalled cycle; bubbles travel too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (!w_stall) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    // Data registers advance in lock-step with the valid bits and clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (!w_stall) begin
            r_c <= w_c_nxt;
            for (int k = 0; k < STAGES; k++) begin
                r_x[k] <= w_x_nxt[k];
                r_b[k] <= w_b_nxt[k];
                r_s[k] <= w_s_nxt[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the last stage registers. Overflow is
    // signed: equal operand signs producing a result of the other sign.
    // ------------------------------------------------------------------
    assign out_valid = r_valid[c_last];
    assign s         = r_s[c_last];
    assign cout      = r_c[c_last];
    assign ovf       = (r_x[c_last][N-1] == r_b[c_last][N-1])
                     & (r_s[c_last][N-1] != r_x[c_last][N-1]);

endmodule
`default_nettype wire

// File: tb/tb_rca_pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_pipelined_addsub
//  Description : Self-checking bench for rca_pipelined_addsub. Three
//                instances (N=8; STAGES=4, 1, 8) share one stimulus; each has
//                its own scoreboard built on plain signed/unsigned arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rca_pipelined_addsub;

    localparam int c_ncfg = 3;
    localparam int c_stages [c_ncfg] = '{4, 1, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       cin;
    logic       sub;
    logic       out_ready;
    logic       chk_en;
    logic [7:0] x;
    logic [7:0] y;

    logic [c_ncfg-1:0] in_ready_a;
    logic [c_ncfg-1:0] out_valid_a;
    logic [c_ncfg-1:0] cout_a;
    logic [c_ncfg-1:0] ovf_a;
    logic [7:0]        s_a [c_ncfg];

    int tests = 0;
    int fails = 0;
    int nout0 = 0;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         adv;
    } item_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: unsigned result for s/cout, signed result for ovf.
    function automatic item_t model(input logic [7:0] a, input logic [7:0] b,
                                    input logic ci, input logic sb);
        item_t r;
        int    u;
        int    v;
        if (sb) begin
            u   = int'(a) - int'(b) - int'(ci);
            v   = int'($signed(a)) - int'($signed(b)) - int'(ci);
            r.c = (u >= 0);
        end else begin
            u   = int'(a) + int'(b) + int'(ci);
            v   = int'($signed(a)) + int'($signed(b)) + int'(ci);
            r.c = (u > 255);
        end
        r.s   = u[7:0];
        r.o   = (v > 127) || (v < -128);
        r.adv = 0;
        return r;
    endfunction

    // DUT instances with per-instance scoreboards.
    for (genvar g = 0; g < c_ncfg; g++) begin : g_cfg
        localparam int c_st = c_stages[g];
        logic  ordy;
        item_t q[$];

        assign ordy = (g == 0) ? out_ready : 1'b1;

        rca_pipelined_addsub #(.N(8), .STAGES(c_st)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready_a[g]),
            .x        (x),
            .y        (y),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid_a[g]),
            .out_ready(ordy),
            .s        (s_a[g]),
            .cout     (cout_a[g]),
            .ovf      (ovf_a[g])
        );

        // An accepted op is visible after exactly c_st non-stalled edges.
        always @(negedge clk) begin
            bit    ev;
            bit    stl;
            item_t it;
            if (chk_en) begin
                ev  = (q.size() > 0) && (q[0].adv == c_st);
                stl = ev && !ordy;
                check($sformatf("cfg%0d out_valid", g), out_valid_a[g], ev);
                check($sformatf("cfg%0d in_ready", g), in_ready_a[g], !stl);
                if (ev) begin
                    check($sformatf("cfg%0d s", g), s_a[g], q[0].s);
                    check($sformatf("cfg%0d cout", g), cout_a[g], q[0].c);
                    check($sformatf("cfg%0d ovf", g), ovf_a[g], q[0].o);
                end
                if (rst) begin
                    q.delete();
                end else if (!stl) begin
                    if (ev) void'(q.pop_front());
                    foreach (q[j]) q[j].adv++;
                    if (in_valid) begin
                        it     = model(x, y, cin, sub);
                        it.adv = 1;
                        q.push_back(it);
                    end
                end
            end
        end
    end

    // Count results leaving the STAGES=4 instance.
    always @(negedge clk) begin
        if (chk_en && out_valid_a[0] && out_ready) nout0++;
    end

    // Present one op and hold it until the STAGES=4 instance accepts it.
    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
        bit acc;
        int n;
        in_valid = 1'b1;
        x = a; y = b; cin = ci; sub = sb;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready_a[0];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("put timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_rand();
        put(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Single op on an empty pipe: latency and literal result on STAGES=4.
    task automatic directed(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic ci, input logic sb,
                            input logic [7:0] es, input logic ec, input logic eo);
        int n;
        put(a, b, ci, sb);
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_a[0] && n < 20);
        check({nm, " latency"}, n, 4);
        check({nm, " s"}, s_a[0], es);
        check({nm, " cout"}, cout_a[0], ec);
        check({nm, " ovf"}, ovf_a[0], eo);
        idle(10);
    endtask

    initial begin
        item_t it;
        int    base;
        bit    done;
        logic [7:0] s_hold;

        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; chk_en = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < c_ncfg; c++) begin
            check($sformatf("reset cfg%0d out_valid", c), out_valid_a[c], 1'b0);
            check($sformatf("reset cfg%0d in_ready", c), in_ready_a[c], 1'b1);
            check($sformatf("reset cfg%0d s", c), s_a[c], 8'h00);
            check($sformatf("reset cfg%0d cout", c), cout_a[c], 1'b0);
            check($sformatf("reset cfg%0d ovf", c), ovf_a[c], 1'b0);
        end
        chk_en = 1'b1;

        // Pin the reference model against hand-computed results.
        it = model(8'hFF, 8'h01, 1'b0, 1'b0);
        check("model FF+01", {it.s, it.c, it.o}, {8'h00, 1'b1, 1'b0});
        it = model(8'h80, 8'h01, 1'b0, 1'b1);
        check("model 80-01", {it.s, it.c, it.o}, {8'h7F, 1'b1, 1'b1});
        it = model(8'h05, 8'h07, 1'b1, 1'b1);
        check("model 05-07-1", {it.s, it.c, it.o}, {8'hFD, 1'b0, 1'b0});
        it = model(8'h7F, 8'h01, 1'b0, 1'b0);
        check("model 7F+01", {it.s, it.c, it.o}, {8'h80, 1'b0, 1'b1});

        @(posedge clk); #1;

        // Directed arithmetic with full carry ripple and borrow cases.
        directed("add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        directed("sub 05-07-1", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0);
        directed("add 7F+00+1", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

        // Back-to-back stream of 20 random ops.
        base = nout0;
        for (int i = 0; i < 20; i++) put_rand();
        idle(12);
        check("stream result count", nout0 - base, 20);

        // Stream with a 5-cycle downstream stall in the middle.
        base = nout0;
        fork
            begin
                for (int i = 0; i < 15; i++) put_rand();
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                s_hold = s_a[0];
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall s stable", s_a[0], s_hold);
                    check("stall out_valid", out_valid_a[0], 1'b1);
                    check("stall in_ready", in_ready_a[0], 1'b0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(15);
        check("stall result count", nout0 - base, 15);

        // Reset with three ops in flight: nothing may emerge.
        put_rand(); put_rand(); put_rand();
        in_valid = 1'b0;
        rst = 1'b1;
        base = nout0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("flushed results", nout0 - base, 0);
        directed("after rst 12+34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // Random traffic with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    put_rand();
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
